gfx_fb_writer: RTL and testbench
================================

# gfx_fb_writer

Framebuffer write sink for the gfx pixel stream. Accepts (x, y, pixel) beats on a valid/ready slave port, discards off-screen pixels, converts surviving coordinates to a linear framebuffer address (y * h_visible + x), and issues one memory write per pixel on a valid/ready master port. Sits between any gfx producer (rect fill, line, shape sequencers) and the framebuffer memory controller.

## Interface
Parameters:
- H_WIDTH, 12, x coordinate / h_visible width
- V_WIDTH, 12, y coordinate / v_visible width
- PIXEL_WIDTH, 12, pixel color width
- ADDR_WIDTH, 20, framebuffer word address width
- DATA_WIDTH, 16, memory write data width; must be >= PIXEL_WIDTH

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- s_gfx_valid  in  1  pixel beat valid
- s_gfx_x  in  H_WIDTH  pixel x
- s_gfx_y  in  V_WIDTH  pixel y
- s_gfx_pixel  in  PIXEL_WIDTH  pixel color
- s_gfx_ready  out  1  beat accepted when valid && ready
- h_visible  in  H_WIDTH  screen width in pixels
- v_visible  in  V_WIDTH  screen height in pixels
- m_mem_wr_valid  out  1  write request valid
- m_mem_wr_addr  out  ADDR_WIDTH  word address
- m_mem_wr_data  out  DATA_WIDTH  pixel, zero-extended
- m_mem_wr_ready  in  1  write accepted when valid && ready
- idle  out  1  high when no beat is held in any stage
- stat_wr_cnt  out  32  writes issued (only with stats enabled)
- stat_clip_cnt  out  32  pixels discarded (only with stats enabled)

## Operation
- Two-stage pipeline, each stage a valid flag plus payload register.
- S1 (capture): on accept, registers x, y, pixel, h_visible and in_range = (x < h_visible) && (y < v_visible). h_visible/v_visible are sampled only at accept; later changes do not affect beats in flight.
- S2 (address): loaded from S1 only when S1 in_range; addr = y * h_visible_s1 + x, computed at full product width, truncated to ADDR_WIDTH; data = pixel zero-extended. S2 registers drive m_mem_wr_* directly.
- S1 beat with in_range = 0 is dropped when S1 advances (S2 unaffected); counts as a clip.
- Advance rules: S2 frees when !s2_valid || m_mem_wr_ready. S1 advances when s1_valid && (S2 frees || !in_range). s_gfx_ready = !s1_valid || S1 advances.
- idle = !s1_valid && !s2_valid.
- Reset (any time, including mid-stream): s1_valid, s2_valid cleared; in-flight beats lost; no partial write issued.

## Timing
- Reset values: s_gfx_ready 1, m_mem_wr_valid 0, m_mem_wr_addr 0, m_mem_wr_data 0, idle 1, stat counters 0.
- Latency: beat accepted at edge N appears on m_mem_wr_valid after edge N+1 (2 cycles), no backpressure.
- Throughput: 1 beat/cycle sustained while m_mem_wr_ready high, including mixed clipped/in-range beats.
- While m_mem_wr_valid && !m_mem_wr_ready: addr/data held stable; valid never drops.
- s_gfx_ready combinationally depends on m_mem_wr_ready (no skid); consumers must not feed it back into s_gfx_valid.
- Boundaries: x == h_visible or y == v_visible is clipped; x = h_visible-1, y = v_visible-1 writes; h_visible = 0 clips everything.

## Configuration
- GFX_FB_WRITER_STATS_EN defined: stat_wr_cnt increments on each m_mem_wr handshake, stat_clip_cnt on each clipped drop; both saturate at 32'hFFFF_FFFF, cleared only by rst.
- Undefined: stat ports and counters absent; all other behaviour identical.

## Structure
- Package gfx_fb_pkg: typedef for the S1 payload struct (x, y, pixel, h_visible, in_range) and localparam defaults for widths.
- No sub-module; pipeline is small enough inline. Address multiply kept as a single registered expression for synthesis DSP inference.

## Test plan
- Reset mid-stream with S1 and S2 full -> after rst, idle=1, m_mem_wr_valid=0, s_gfx_ready=1; no write issued.
- h_visible=640, v_visible=480, beat (x=5, y=2, pixel=12'hABC), ready high -> 2 cycles later addr=1285, data=16'h0ABC, one write.
- Beats (639,479), (640,0), (0,480) -> only first writes, addr=307199; with stats enabled stat_clip_cnt=2, stat_wr_cnt=1.
- Back-to-back 16 in-range beats, m_mem_wr_ready toggled 1/0 each cycle -> 16 writes in order, addr/data stable during stalls, no loss or duplication.
- m_mem_wr_ready held 0 -> exactly 2 beats accepted then s_gfx_ready=0; clipped beat behind stalled S2 still drains from S1.
- h_visible changed 640->320 with beat in S1 -> that beat's address uses 640; next accepted beat uses 320.

Source files
------------

// File: rtl/gfx_fb_pkg.sv
// Shared widths and the capture-stage payload type for the framebuffer writer.
package gfx_fb_pkg;

    localparam int GFX_H_WIDTH     = 12;
    localparam int GFX_V_WIDTH     = 12;
    localparam int GFX_PIXEL_WIDTH = 12;
    localparam int GFX_ADDR_WIDTH  = 20;
    localparam int GFX_DATA_WIDTH  = 16;

    typedef struct packed {
        logic [GFX_H_WIDTH-1:0]     x;
        logic [GFX_V_WIDTH-1:0]     y;
        logic [GFX_PIXEL_WIDTH-1:0] pixel;
        logic [GFX_H_WIDTH-1:0]     h_visible;
        logic                       in_range;
    } s1_payload_t;

endpackage

// File: rtl/gfx_fb_writer.sv
// Framebuffer write sink: clips (x,y,pixel) beats and issues linear-address writes; optional counters via GFX_FB_WRITER_STATS_EN.
// Latency: 2 cycles from accept to m_mem_wr_valid; 1 beat/cycle sustained.
// Backpressure: s_gfx_ready is combinational on m_mem_wr_ready; clipped beats drain even while S2 stalls.
module gfx_fb_writer
    import gfx_fb_pkg::*;
#(
    parameter int H_WIDTH     = GFX_H_WIDTH,
    parameter int V_WIDTH     = GFX_V_WIDTH,
    parameter int PIXEL_WIDTH = GFX_PIXEL_WIDTH,
    parameter int ADDR_WIDTH  = GFX_ADDR_WIDTH,
    parameter int DATA_WIDTH  = GFX_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_gfx_valid,
    input  logic [H_WIDTH-1:0]     s_gfx_x,
    input  logic [V_WIDTH-1:0]     s_gfx_y,
    input  logic [PIXEL_WIDTH-1:0] s_gfx_pixel,
    output logic                   s_gfx_ready,
    input  logic [H_WIDTH-1:0]     h_visible,
    input  logic [V_WIDTH-1:0]     v_visible,
    output logic                   m_mem_wr_valid,
    output logic [ADDR_WIDTH-1:0]  m_mem_wr_addr,
    output logic [DATA_WIDTH-1:0]  m_mem_wr_data,
    input  logic                   m_mem_wr_ready,
    output logic                   idle
`ifdef GFX_FB_WRITER_STATS_EN
    ,
    output logic [31:0]            stat_wr_cnt,
    output logic [31:0]            stat_clip_cnt
`endif
);

    localparam int PROD_W = H_WIDTH + V_WIDTH;

    s1_payload_t s1_q;
    logic        s1_valid;
    logic        s2_valid;
    logic        s2_free;
    logic        s1_adv;
    logic        s1_accept;
    logic        s2_load;

    assign s2_free        = !s2_valid || m_mem_wr_ready;
    // An off-screen beat never needs S2, so it leaves S1 even when S2 is stalled.
    assign s1_adv         = s1_valid && (s2_free || !s1_q.in_range);
    assign s_gfx_ready    = !s1_valid || s1_adv;
    assign s1_accept      = s_gfx_valid && s_gfx_ready;
    assign s2_load        = s1_adv && s1_q.in_range;
    assign m_mem_wr_valid = s2_valid;
    assign idle           = !s1_valid && !s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_accept) begin
            s1_valid <= 1'b1;
            s1_q     <= '{x:         s_gfx_x,
                          y:         s_gfx_y,
                          pixel:     s_gfx_pixel,
                          h_visible: h_visible,
                          in_range:  (s_gfx_x < h_visible) && (s_gfx_y < v_visible)};
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Single multiply-add expression so synthesis can map it onto one DSP slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            m_mem_wr_addr <= '0;
            m_mem_wr_data <= '0;
        end else if (s2_load) begin
            s2_valid      <= 1'b1;
            m_mem_wr_addr <= ADDR_WIDTH'(PROD_W'(s1_q.y) * PROD_W'(s1_q.h_visible) + PROD_W'(s1_q.x));
            m_mem_wr_data <= DATA_WIDTH'(s1_q.pixel);
        end else if (m_mem_wr_ready) begin
            s2_valid      <= 1'b0;
        end
    end

`ifdef GFX_FB_WRITER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_wr_cnt   <= '0;
            stat_clip_cnt <= '0;
        end else begin
            if (m_mem_wr_valid && m_mem_wr_ready && (stat_wr_cnt != 32'hFFFF_FFFF))
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
            if (s1_adv && !s1_q.in_range && (stat_clip_cnt != 32'hFFFF_FFFF))
                stat_clip_cnt <= stat_clip_cnt + 32'd1;
        end
    end
`else
    // Stats build option off: no counters and no stat ports.
`endif

endmodule

// File: tb/tb_gfx_fb_writer.sv
// Directed + randomized bench for gfx_fb_writer against a coordinate-level write model.
`timescale 1ns/1ps
module tb_gfx_fb_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_gfx_valid = 1'b0;
    logic [11:0] s_gfx_x = '0;
    logic [11:0] s_gfx_y = '0;
    logic [11:0] s_gfx_pixel = '0;
    logic        s_gfx_ready;
    logic [11:0] h_visible = 12'd640;
    logic [11:0] v_visible = 12'd480;
    logic        m_mem_wr_valid;
    logic [19:0] m_mem_wr_addr;
    logic [15:0] m_mem_wr_data;
    logic        m_mem_wr_ready = 1'b1;
    logic        idle;
`ifdef GFX_FB_WRITER_STATS_EN
    logic [31:0] stat_wr_cnt;
    logic [31:0] stat_clip_cnt;
`endif

    gfx_fb_writer dut (
        .clk            (clk),
        .rst            (rst),
        .s_gfx_valid    (s_gfx_valid),
        .s_gfx_x        (s_gfx_x),
        .s_gfx_y        (s_gfx_y),
        .s_gfx_pixel    (s_gfx_pixel),
        .s_gfx_ready    (s_gfx_ready),
        .h_visible      (h_visible),
        .v_visible      (v_visible),
        .m_mem_wr_valid (m_mem_wr_valid),
        .m_mem_wr_addr  (m_mem_wr_addr),
        .m_mem_wr_data  (m_mem_wr_data),
        .m_mem_wr_ready (m_mem_wr_ready),
        .idle           (idle)
`ifdef GFX_FB_WRITER_STATS_EN
        ,
        .stat_wr_cnt    (stat_wr_cnt),
        .stat_clip_cnt  (stat_clip_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  obs_addr_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  acc_cnt = 0;
    int  wr_cnt = 0;
    bit  prev_stall = 0;
    int  prev_addr = 0;
    int  prev_data = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: every accepted on-screen beat must produce exactly one write, in order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_hold", m_mem_wr_valid, 1);
                chk("stall_addr_hold", m_mem_wr_addr, prev_addr);
                chk("stall_data_hold", m_mem_wr_data, prev_data);
            end
            prev_stall = m_mem_wr_valid && !m_mem_wr_ready;
            prev_addr  = int'(m_mem_wr_addr);
            prev_data  = int'(m_mem_wr_data);
            if (m_mem_wr_valid && m_mem_wr_ready) begin
                wr_cnt++;
                obs_addr_q.push_back(int'(m_mem_wr_addr));
                chk("write_was_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", m_mem_wr_addr, e.addr);
                    chk("write_data", m_mem_wr_data, e.data);
                end
            end
            if (s_gfx_valid && s_gfx_ready) begin
                int x, y, hv, vv;
                acc_cnt++;
                x  = int'(s_gfx_x);
                y  = int'(s_gfx_y);
                hv = int'(h_visible);
                vv = int'(v_visible);
                if (x < hv && y < vv)
                    exp_q.push_back('{addr: (y * hv + x) % (1 << 20), data: int'(s_gfx_pixel)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input int p);
        int c = 0;
        s_gfx_valid = 1'b1;
        s_gfx_x     = 12'(x);
        s_gfx_y     = 12'(y);
        s_gfx_pixel = 12'(p);
        @(negedge clk);
        while (!s_gfx_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("send_accepted", s_gfx_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int c = 0;
        s_gfx_valid    = 1'b0;
        m_mem_wr_ready = 1'b1;
        while (!(idle && exp_q.size() == 0) && c < 100) begin
            tick();
            c++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_idle"}, idle, 1);
    endtask

    // mode 0: ready high, 1: ready toggles, 2: ready random
    task automatic run_stream(input int n, input int mode, input bit allow_clip);
        int idx = 0;
        int cyc = 0;
        bit acc;
        logic [11:0] bx, by, bp;
        bx = allow_clip ? 12'($urandom_range(0, int'(h_visible) + 3)) : 12'($urandom_range(0, int'(h_visible) - 1));
        by = allow_clip ? 12'($urandom_range(0, int'(v_visible) + 3)) : 12'($urandom_range(0, int'(v_visible) - 1));
        bp = 12'($urandom);
        while (idx < n && cyc < 1000) begin
            s_gfx_valid    = 1'b1;
            s_gfx_x        = bx;
            s_gfx_y        = by;
            s_gfx_pixel    = bp;
            m_mem_wr_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = s_gfx_ready;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                bx = allow_clip ? 12'($urandom_range(0, int'(h_visible) + 3)) : 12'($urandom_range(0, int'(h_visible) - 1));
                by = allow_clip ? 12'($urandom_range(0, int'(v_visible) + 3)) : 12'($urandom_range(0, int'(v_visible) - 1));
                bp = 12'($urandom);
            end
        end
        s_gfx_valid    = 1'b0;
        m_mem_wr_ready = 1'b1;
        chk("stream_all_accepted", idx, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, a0;

        // reset state
        tick();
        chk("rst_ready", s_gfx_ready, 1);
        chk("rst_wr_valid", m_mem_wr_valid, 0);
        chk("rst_wr_addr", m_mem_wr_addr, 0);
        chk("rst_wr_data", m_mem_wr_data, 0);
        chk("rst_idle", idle, 1);
`ifdef GFX_FB_WRITER_STATS_EN
        chk("rst_stat_wr", stat_wr_cnt, 0);
        chk("rst_stat_clip", stat_clip_cnt, 0);
`endif
        rst = 1'b0;
        tick();

        // single beat latency and address
        w0 = wr_cnt;
        send(5, 2, 12'hABC);
        s_gfx_valid = 1'b0;
        chk("lat_n_valid", m_mem_wr_valid, 0);
        tick();
        chk("lat_n1_valid", m_mem_wr_valid, 1);
        chk("lat_n1_addr", m_mem_wr_addr, 1285);
        chk("lat_n1_data", m_mem_wr_data, 16'h0ABC);
        drain("single");
        chk("single_one_write", wr_cnt - w0, 1);

        // edge coordinates
        w0 = wr_cnt;
        send(639, 479, 12'h123);
        send(640, 0, 12'h456);
        send(0, 480, 12'h789);
        drain("edges");
        chk("edges_one_write", wr_cnt - w0, 1);
        chk("edges_addr", obs_addr_q[obs_addr_q.size() - 1], 307199);
`ifdef GFX_FB_WRITER_STATS_EN
        chk("edges_stat_wr", stat_wr_cnt, 2);
        chk("edges_stat_clip", stat_clip_cnt, 2);
`endif

        // back-to-back with toggling ready
        w0 = wr_cnt;
        run_stream(16, 1, 1'b0);
        drain("toggle");
        chk("toggle_16_writes", wr_cnt - w0, 16);

        // sink fully stalled: two beats fill the pipe
        a0 = acc_cnt;
        m_mem_wr_ready = 1'b0;
        s_gfx_valid = 1'b1;
        s_gfx_x = 12'd7;
        s_gfx_y = 12'd7;
        s_gfx_pixel = 12'h0F0;
        repeat (8) tick();
        chk("stall_two_accepts", acc_cnt - a0, 2);
        chk("stall_ready_low", s_gfx_ready, 0);
        chk("stall_wr_valid", m_mem_wr_valid, 1);
        drain("stall");

        // clipped beat drains past stalled S2
        a0 = acc_cnt;
        m_mem_wr_ready = 1'b0;
        send(3, 3, 12'h001);
        send(700, 3, 12'h002);
        send(4, 3, 12'h003);
        s_gfx_valid = 1'b0;
        tick();
        chk("clip_drain_accepts", acc_cnt - a0, 3);
        chk("clip_drain_ready_low", s_gfx_ready, 0);
        drain("clip_drain");

        // h_visible change while a beat sits in S1
        send(10, 3, 12'h005);
        h_visible = 12'd320;
        send(10, 3, 12'h006);
        s_gfx_valid = 1'b0;
        drain("hvis");
        chk("hvis_old_width", obs_addr_q[obs_addr_q.size() - 2], 1930);
        chk("hvis_new_width", obs_addr_q[obs_addr_q.size() - 1], 970);

        // zero width clips everything
        w0 = wr_cnt;
        h_visible = 12'd0;
        send(0, 0, 12'h001);
        send(5, 5, 12'h002);
        drain("hzero");
        chk("hzero_no_writes", wr_cnt - w0, 0);

        // randomized mixed traffic with random backpressure
        for (int r = 0; r < 3; r++) begin
            h_visible = 12'($urandom_range(1, 40));
            v_visible = 12'($urandom_range(1, 40));
            run_stream(60, 2, 1'b1);
            drain("random");
        end

        // reset with both stages full
        h_visible = 12'd640;
        v_visible = 12'd480;
        m_mem_wr_ready = 1'b0;
        send(1, 1, 12'h011);
        send(2, 2, 12'h022);
        s_gfx_valid = 1'b0;
        chk("prerst_busy", idle, 0);
        w0 = wr_cnt;
        rst = 1'b1;
        #2;
        chk("midrst_idle", idle, 1);
        chk("midrst_wr_valid", m_mem_wr_valid, 0);
        chk("midrst_ready", s_gfx_ready, 1);
        tick();
        rst = 1'b0;
        m_mem_wr_ready = 1'b1;
        repeat (5) tick();
        chk("postrst_no_write", wr_cnt - w0, 0);
        chk("postrst_idle", idle, 1);
`ifdef GFX_FB_WRITER_STATS_EN
        chk("postrst_stat_wr", stat_wr_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
